dct_add_sched: RTL and testbench
================================

// Module: dct_add_sched
// PURPOSE
//  Sequencer for the bit-skewed pipelined adder of the 1D-DCT datapath.
//  Per job it issues n rows (1..8) through three passes: Q=0, Q=1, then Q=2.
//  Each issued row uses a per-{stage,row} sign pattern (op).
//  Q=2 consumes the Y0/Y1 feedback produced by the earlier passes, so this block
//  holds Q=2 issue until the last Q=1 result has emerged. It tags each adder
//  result with its stage and row.
// PARAMETERS
//  LAT    9  cycles from an issue cycle (op/q/sel driven) to valid add_s
//  NROWS  8  maximum rows per job; also the op-table depth per stage
// PORTS
//  clk        in   1   clock, all logic rising-edge
//  rst        in   1   synchronous reset, active-high
//  start      in   1   job request; sampled only in IDLE
//  nrows      in   4   rows for the job, 1..8; 0 or >8 is treated as 8
//  busy       out  1   job in progress
//  done       out  1   1-cycle pulse, coincident with the last res_valid of the job
//  cfg_we     in   1   op-table write strobe
//  cfg_addr   in   5   {stage[1:0],row[2:0]}; stage 3 is ignored
//  cfg_data   in   8   sign pattern; bit k=1 negates operand pair k
//  add_op     out  8   to adder op
//  add_q      out  2   to adder Q
//  add_sel    out  3   row index for the external operand mux
//  add_s      in   9   adder sum S
//  res_valid  out  1   add_s is valid this cycle
//  res_stage  out  2   stage tag of res_data
//  res_row    out  3   row tag of res_data
//  res_data   out  9   add_s passed through when res_valid=1
// BEHAVIOUR
//  - Reset: every output is 0, FSM goes to IDLE, the tag pipe is cleared, and all 24
//    op-table entries become 0. Reset mid-job aborts the job: no done pulse, and
//    results already in flight are never flagged valid.
//  - FSM states: IDLE, ISSUE0, ISSUE1, WAIT, ISSUE2, DRAIN.
//    - IDLE & start: latch n, row counter r=0, go to ISSUE0 (first issue cycle is
//      the next cycle). start while not IDLE is ignored.
//    - ISSUEs: 1 row per cycle: add_q=s, add_sel=r, add_op=tbl[s][r], r++.
//      At r=n-1, reset r=0 and advance to the next state.
//      ISSUE0 -> ISSUE1 is back-to-back; ISSUE1 -> WAIT.
//    - WAIT: exactly LAT cycles, so the last Q=1 result is valid before the
//      first Q=2 issue. WAIT -> ISSUE2 -> DRAIN.
//    - DRAIN: ends on the cycle the last Q=2 result is valid. done=1 that cycle;
//      FSM returns to IDLE on the next cycle.
//  - Non-issue cycles (IDLE/WAIT/DRAIN): add_op=0, add_q=0, add_sel=0; these are
//    bubbles and are never flagged valid.
//  - Tag pipe: LAT-deep shift register of {valid,stage,row}. Its output drives
//    res_valid/res_stage/res_row. res_data = add_s when valid, else 0.
//  - busy=1 from the first ISSUE0 cycle through the done cycle inclusive.
//  - Total busy cycles = 3n + 2*LAT (42 for n=8, LAT=9).
//  - Op table: written when cfg_we=1 and not busy, taking effect on the next cycle.
//    Writes while busy are dropped, so the table is stable for a whole job.
//  - A start in the same cycle as done is ignored, because the FSM is not yet IDLE.
// CONFIGURATION
//  DCT_ADD_SCHED_PERF_EN defined: adds output perf_cycles[15:0].
//    - Counts busy cycles of the current job, saturating at 16'hFFFF.
//    - Holds the final count after done; cleared at the next accepted start and by rst.
//  Undefined: no perf_cycles port and no counter logic; all other behaviour is
//  identical.
// TESTING
//  - Reset all 24 table entries to 0. nrows=8, start pulse at cycle 0:
//    - ISSUE0 cycles 1-8 with add_q=0, ISSUE1 cycles 9-16, WAIT cycles 17-25.
//    - ISSUE2 cycles 26-33 with add_q=2.
//    - done=1 at cycle 42, busy=0 at cycle 43.
//  - Write tbl[1][3]=8'hA5, then run nrows=8: add_op=A5 and add_sel=3 at cycle 12;
//    res_valid at cycle 21 with stage=1, row=3.
//  - nrows=1: 1 issue per stage, done at cycle 21 (3+18). nrows=0 behaves as nrows=8.
//  - cfg_we during busy writing 8'hFF to tbl[0][0]: table unchanged; the next job
//    issues add_op=00 for stage 0, row 0.
//  - rst asserted at cycle 20 of a job: all outputs 0 next cycle, no res_valid and no
//    done afterwards. start at cycle 25 is then accepted normally.
//  - start held high through a whole job: exactly one job runs, and the next is
//    accepted on the first IDLE cycle after done. With PERF_EN: perf_cycles=42.

Source files
------------

// File: rtl/dct_add_sched.sv
// Sequencer for the bit-skewed pipelined adder of the 1D-DCT datapath.
// Issues n rows through passes Q=0, Q=1, waits for the Q=1 feedback, then issues
// Q=2 and tags every adder result with its {stage,row}.
// Optional feature: define DCT_ADD_SCHED_PERF_EN to add the perf_cycles counter.
module dct_add_sched #(
  parameter int unsigned LAT   = 9,
  parameter int unsigned NROWS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  nrows,
  output logic        busy,
  output logic        done,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic [7:0]  add_op,
  output logic [1:0]  add_q,
  output logic [2:0]  add_sel,
  input  logic [8:0]  add_s,
  output logic        res_valid,
  output logic [1:0]  res_stage,
  output logic [2:0]  res_row,
  output logic [8:0]  res_data
`ifdef DCT_ADD_SCHED_PERF_EN
  ,
  output logic [15:0] perf_cycles
`endif
);

  localparam int unsigned CW = $clog2(LAT);

  typedef enum logic [2:0] {StIdle, StIssue0, StIssue1, StWait, StIssue2, StDrain} state_e;

  state_e          state_q, state_d;
  logic [2:0]      r_q, r_d;
  logic [2:0]      last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            issue;
  logic [1:0]      stg;
  logic [3:0]      nrows_m1;
  logic [2:0]      n_m1;
  logic [7:0]      tbl [3][NROWS];
  logic [5:0]      pipe_q [LAT];

  assign busy = (state_q != StIdle);

  // Out-of-range row counts fall back to a full job of 8 rows.
  assign nrows_m1 = nrows - 4'd1;
  assign n_m1     = (nrows == 4'd0 || nrows > 4'd8) ? 3'd7 : nrows_m1[2:0];

  // Next-state logic and issue decode.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    stg     = 2'd0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          last_d  = n_m1;
          r_d     = 3'd0;
          state_d = StIssue0;
        end
      end
      StIssue0, StIssue1, StIssue2: begin
        issue = 1'b1;
        stg   = (state_q == StIssue0) ? 2'd0 : (state_q == StIssue1) ? 2'd1 : 2'd2;
        if (r_q == last_q) begin
          r_d     = 3'd0;
          cnt_d   = '0;
          state_d = (state_q == StIssue0) ? StIssue1 :
                    (state_q == StIssue1) ? StWait : StDrain;
        end else begin
          r_d = r_q + 3'd1;
        end
      end
      StWait: begin
        // Holds Q=2 until the last Q=1 result is back on add_s.
        if (cnt_q == CW'(LAT - 1)) begin
          cnt_d   = '0;
          state_d = StIssue2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == CW'(LAT - 1)) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Adder drive; bubbles carry all-zero op/q/sel.
  always_comb begin
    add_q   = issue ? stg : 2'd0;
    add_sel = issue ? r_q : 3'd0;
    add_op  = issue ? tbl[stg][r_q] : 8'd0;
  end

  // FSM state, row counter and wait/drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= 3'd0;
      last_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Op table; writes are dropped while busy so a job sees a stable table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 3; s++) begin
        for (int r = 0; r < int'(NROWS); r++) begin
          tbl[s][r] <= 8'd0;
        end
      end
    end else if (cfg_we && !busy && cfg_addr[4:3] != 2'd3) begin
      tbl[cfg_addr[4:3]][cfg_addr[2:0]] <= cfg_data;
    end
  end

  // Tag pipe aligned with the adder latency; reset drops in-flight tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) begin
        pipe_q[i] <= 6'd0;
      end
    end else begin
      pipe_q[0] <= {issue, add_q, add_sel};
      for (int i = 1; i < int'(LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign res_valid = pipe_q[LAT-1][5];
  assign res_stage = pipe_q[LAT-1][4:3];
  assign res_row   = pipe_q[LAT-1][2:0];
  assign res_data  = res_valid ? add_s : 9'd0;

`ifdef DCT_ADD_SCHED_PERF_EN
  logic [15:0] perf_q;

  // Busy-cycle counter: cleared on an accepted start, saturating, held after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 16'd0;
    end else if (state_q == StIdle && start) begin
      perf_q <= 16'd0;
    end else if (busy && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_dct_add_sched.sv
// Self-checking bench for dct_add_sched: random tables, row counts and adder sums
// compared each cycle against a schedule computed directly from the job rules.
module tb_dct_add_sched;

  localparam int LAT = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  nrows;
  logic        busy;
  logic        done;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [7:0]  add_op;
  logic [1:0]  add_q;
  logic [2:0]  add_sel;
  logic [8:0]  add_s;
  logic        res_valid;
  logic [1:0]  res_stage;
  logic [2:0]  res_row;
  logic [8:0]  res_data;
`ifdef DCT_ADD_SCHED_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int prev_len = 0;
  logic [7:0] mtbl [3][8];

  always #5 clk = ~clk;

  dct_add_sched #(.LAT(LAT), .NROWS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nrows     (nrows),
    .busy      (busy),
    .done      (done),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .add_op    (add_op),
    .add_q     (add_q),
    .add_sel   (add_sel),
    .add_s     (add_s),
    .res_valid (res_valid),
    .res_stage (res_stage),
    .res_row   (res_row),
    .res_data  (res_data)
`ifdef DCT_ADD_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_op"}, add_op, 0);
    check({tag, "_q"}, add_q, 0);
    check({tag, "_sel"}, add_sel, 0);
    check({tag, "_rv"}, res_valid, 0);
    check({tag, "_rs"}, res_stage, 0);
    check({tag, "_rr"}, res_row, 0);
    check({tag, "_rd"}, res_data, 0);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    cyc();
    cfg_we = 1'b0;
    if (a[4:3] != 2'd3) mtbl[a[4:3]][a[2:0]] = d;
  endtask

  // One job, starting with the start cycle (cycle 0) and ending after cycle 3n+2*LAT.
  task automatic run_job(input int nr, input bit hold, input bit wr_busy);
    int n;
    int len;
    bit ev [64];
    int eq [64];
    int es [64];
    bit rv;
    int ic;
    n = (nr == 0 || nr > 8) ? 8 : nr;
    len = 3 * n + 2 * LAT;
    for (int c = 0; c < 64; c++) begin
      ev[c] = 1'b0; eq[c] = 0; es[c] = 0;
    end
    for (int i = 0; i < n; i++) begin
      ev[1 + i] = 1'b1;             eq[1 + i] = 0;             es[1 + i] = i;
      ev[1 + n + i] = 1'b1;         eq[1 + n + i] = 1;         es[1 + n + i] = i;
      ev[2 * n + LAT + 1 + i] = 1'b1; eq[2 * n + LAT + 1 + i] = 2; es[2 * n + LAT + 1 + i] = i;
    end
    start = 1'b1;
    nrows = 4'(nr);
    add_s = 9'($urandom);
    @(negedge clk);
    check("idle_busy", busy, 0);
`ifdef DCT_ADD_SCHED_PERF_EN
    check("perf", perf_cycles, prev_len);
`endif
    cyc();
    start = hold;
    for (int c = 1; c <= len; c++) begin
      add_s = 9'($urandom);
      cfg_we = wr_busy && (c == 5);
      cfg_addr = 5'd0;
      cfg_data = 8'hFF;
      @(negedge clk);
      check("busy", busy, 1);
      check("done", done, c == len);
      check("add_q", add_q, ev[c] ? eq[c] : 0);
      check("add_sel", add_sel, ev[c] ? es[c] : 0);
      check("add_op", add_op, ev[c] ? mtbl[eq[c]][es[c]] : 8'd0);
      rv = 1'b0;
      ic = 0;
      if (c > LAT) begin
        ic = c - LAT;
        rv = ev[ic];
      end
      check("res_valid", res_valid, rv);
      check("res_stage", res_stage, rv ? eq[ic] : 0);
      check("res_row", res_row, rv ? es[ic] : 0);
      check("res_data", res_data, rv ? add_s : 9'd0);
      cyc();
      cfg_we = 1'b0;
    end
    start = 1'b0;
    prev_len = len;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; nrows = 4'd0; cfg_we = 1'b0; cfg_addr = 5'd0;
    cfg_data = 8'd0; add_s = 9'd0;
    for (int s = 0; s < 3; s++) for (int r = 0; r < 8; r++) mtbl[s][r] = 8'd0;
    cyc();
    cyc();
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    cyc();

    // All-zero table, full job.
    run_job(8, 1'b0, 1'b0);

    // Targeted entry plus random entries, including ignored stage-3 addresses.
    cfg_write({2'd1, 3'd3}, 8'hA5);
    for (int i = 0; i < 12; i++) cfg_write(5'($urandom), 8'($urandom));
    cfg_write({2'd3, 3'd3}, 8'h5A);
    run_job(8, 1'b0, 1'b0);
    run_job(1, 1'b0, 1'b0);
    run_job(0, 1'b0, 1'b0);
    run_job(9 + int'($urandom_range(0, 6)), 1'b0, 1'b0);

    // Writes while busy are dropped.
    cfg_write(5'd0, 8'h00);
    run_job(8, 1'b0, 1'b1);
    run_job(3, 1'b0, 1'b0);

    // start held through a job, including the done cycle.
    run_job(5, 1'b1, 1'b0);
    run_job(2, 1'b0, 1'b0);

    // Mid-job reset aborts the job and clears the table.
    for (int i = 0; i < 6; i++) cfg_write(5'($urandom_range(0, 23)), 8'($urandom_range(1, 255)));
    start = 1'b1;
    nrows = 4'd8;
    cyc();
    start = 1'b0;
    for (int c = 1; c < 20; c++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) for (int r = 0; r < 8; r++) mtbl[s][r] = 8'd0;
    prev_len = 0;
    for (int c = 21; c < 25; c++) begin
      add_s = 9'($urandom);
      @(negedge clk);
      check_quiet("abort");
      cyc();
    end
    run_job(4, 1'b0, 1'b0);

    for (int j = 0; j < 4; j++) begin
      cfg_write(5'($urandom), 8'($urandom));
      run_job(int'($urandom_range(0, 15)), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
